// File: rtl/coffee_change_dispenser_if.sv
// coffee_change_dispenser_if: request, hopper handshake, refill and status signals of the change dispenser
interface coffee_change_dispenser_if #(
   parameter int AMT_W = 4,
   parameter int INV_W = 6
);
   logic             req;
   logic [AMT_W-1:0] amount;
   logic             refill5;
   logic             refill10;
   logic             hopper_ack;
   logic             coin5_out;
   logic             coin10_out;
   logic             busy;
   logic             done;
   logic             short;
   logic [AMT_W-1:0] remaining;
   logic [INV_W-1:0] inv5;
   logic [INV_W-1:0] inv10;
   logic [2:0]       current_state;
   modport master (
      output req, amount, refill5, refill10, hopper_ack,
      input  coin5_out, coin10_out, busy, done, short, remaining, inv5, inv10, current_state
   );
   modport slave (
      input  req, amount, refill5, refill10, hopper_ack,
      output coin5_out, coin10_out, busy, done, short, remaining, inv5, inv10, current_state
   );
endinterface

// File: rtl/coffee_change_dispenser.sv
// coffee_change_dispenser: pays change from 10-coin then 5-coin hoppers, one hold-until-ack coin at a time.
// Optional CHANGE_TIMEOUT_EN: a coin unacked for ACK_TIMEOUT DISPENSE cycles aborts the payout to FAULT.
module coffee_change_dispenser #(
   parameter int AMT_W       = 4,
   parameter int INV_W       = 6,
   parameter int INIT_COIN5  = 8,
   parameter int INIT_COIN10 = 8
`ifdef CHANGE_TIMEOUT_EN
   , parameter int ACK_TIMEOUT = 15
`endif
) (
   input logic clk,
   input logic rst,
   coffee_change_dispenser_if.slave bus
);
   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      SELECT   = 3'd1,
      DISPENSE = 3'd2,
      DONE     = 3'd3,
      FAULT    = 3'd4
   } state_t;
   state_t           state, state_nx;
   logic [AMT_W-1:0] remaining;
   logic [INV_W-1:0] inv5, inv10;
   logic             short_r, sel10, ack, dec5, dec10, pick10, timed_out;
   function automatic logic [INV_W-1:0] bump(input logic [INV_W-1:0] v, input logic inc, input logic dec);
      return (inc && !dec) ? (&v ? v : v + 1'b1) : (dec && !inc) ? v - 1'b1 : v;
   endfunction
   assign ack    = (state == DISPENSE) && bus.hopper_ack;
   assign dec10  = ack && sel10;
   assign dec5   = ack && !sel10;
   assign pick10 = (remaining >= AMT_W'(2)) && (inv10 != '0);
`ifdef CHANGE_TIMEOUT_EN
   logic [7:0] ack_wait;
   always_ff @(posedge clk)
      if (rst || state != DISPENSE) ack_wait <= '0;
      else if (!bus.hopper_ack) ack_wait <= ack_wait + 8'd1;
   assign timed_out = (state == DISPENSE) && !bus.hopper_ack && (ack_wait == 8'(ACK_TIMEOUT - 1));
`else
   assign timed_out = 1'b0;
`endif
   always_comb begin
      state_nx = IDLE;
      case (state)
         IDLE:     state_nx = bus.req ? ((bus.amount == '0) ? DONE : SELECT) : IDLE;
         SELECT:   state_nx = (pick10 || (remaining != '0 && inv5 != '0)) ? DISPENSE :
                              (remaining == '0) ? DONE : FAULT;
         DISPENSE: state_nx = ack ? SELECT : timed_out ? FAULT : DISPENSE;
         default:  state_nx = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         remaining <= '0;
         short_r   <= 1'b0;
         sel10     <= 1'b0;
         inv5      <= INV_W'(INIT_COIN5);
         inv10     <= INV_W'(INIT_COIN10);
      end else begin
         state <= state_nx;
         if (state == IDLE && bus.req) begin
            remaining <= bus.amount;
            short_r   <= 1'b0;
         end else if (dec10) remaining <= remaining - AMT_W'(2);
         else if (dec5) remaining <= remaining - AMT_W'(1);
         // short rises on FAULT entry so it is already valid alongside the done pulse
         if (state_nx == FAULT) short_r <= 1'b1;
         if (state == SELECT) sel10 <= pick10;
         inv5  <= bump(inv5, bus.refill5, dec5);
         inv10 <= bump(inv10, bus.refill10, dec10);
      end
   end
   assign bus.coin5_out     = (state == DISPENSE) && !sel10;
   assign bus.coin10_out    = (state == DISPENSE) && sel10;
   assign bus.busy          = state != IDLE;
   assign bus.done          = (state == DONE) || (state == FAULT);
   assign bus.short         = short_r;
   assign bus.remaining     = remaining;
   assign bus.inv5          = inv5;
   assign bus.inv10         = inv10;
   assign bus.current_state = state;
endmodule
